// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_pkg                                                      |
// | Purpose  : Shared types, constants and helpers for the MMIO UART         |
// |            transmitter (state enum, TX data address, baud divider).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_e;

   localparam logic [31:0] UART_TX_ADDR = 32'h4000_0000;

   // Clock cycles per serial bit.
   function automatic int uart_div(input int clk, input int baud);
      return clk / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_fifo                                                     |
// | Purpose  : Synchronous FIFO holding bytes waiting for transmission.      |
// |            A push on a full FIFO is accepted only when a pop happens in  |
// |            the same cycle; a pop on an empty FIFO is ignored.            |
// | Ports    : clk_i, rst_ni (sync, active-low), push_i, pop_i, data_i,      |
// |            data_o (head entry), full_o, empty_o, count_o (occupancy)     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int                 C_PTR_W    = $clog2(DEPTH);
   localparam int                 C_CNT_W    = $clog2(DEPTH + 1);
   localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(DEPTH);

   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
         $error("uart_fifo: DEPTH must be a power of two >= 2");
      end
   endgenerate

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [C_PTR_W-1:0] r_wr_ptr;
   logic [C_PTR_W-1:0] r_rd_ptr;
   logic [C_CNT_W-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   assign w_pop  = pop_i && (r_count != '0);
   assign w_push = push_i && ((r_count != C_CNT_FULL) || w_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
         r_count <= r_count + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= data_i;
   end

   assign data_o  = r_mem[r_rd_ptr];
   assign full_o  = (r_count == C_CNT_FULL);
   assign empty_o = (r_count == '0);
   assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_mmio                                                  |
// | Purpose  : Memory-mapped 8N1 UART transmitter. Byte writes to TX_ADDR    |
// |            (dbus_en_i[0] set) are buffered and serialised onto tx_o.     |
// | Config   : UART_TX_FIFO_EN defined -> FIFO of FIFO_DEPTH entries;        |
// |            undefined -> single holding register (depth 1).              |
// | Ports    : clk_i, rst_ni (sync, active-low)                              |
// |            dbus_en_i[3:0], dbus_write_addr_i[31:0], dbus_write_data_i    |
// |            tx_o (idle high), busy_o, full_o, overflow_o (sticky)         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int          CLK_FREQ   = 100_000_000,
   parameter int          BAUD       = 1_000_000,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] TX_ADDR    = UART_TX_ADDR
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [3:0]  dbus_en_i,
   input  logic [31:0] dbus_write_addr_i,
   input  logic [31:0] dbus_write_data_i,
   output logic        tx_o,
   output logic        busy_o,
   output logic        full_o,
   output logic        overflow_o
);

   localparam int C_DIV   = uart_div(CLK_FREQ, BAUD);
   localparam int C_CNT_W = (C_DIV < 2) ? 1 : $clog2(C_DIV);
`ifdef UART_TX_FIFO_EN
   localparam int C_DEPTH = FIFO_DEPTH;
`else
   localparam int C_DEPTH = 1;
`endif
   localparam int                 C_OCC_W    = $clog2(C_DEPTH + 1);
   localparam logic [C_OCC_W-1:0] C_OCC_FULL = C_OCC_W'(C_DEPTH);
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_DIV - 1);

   generate
      if (C_DIV < 2) begin : g_div_check
         $error("uart_tx_mmio: CLK_FREQ/BAUD must be >= 2");
      end
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
         $error("uart_tx_mmio: FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

   // Byte lanes 1..3 are never transmitted.
   logic w_unused;
   assign w_unused = ^{dbus_en_i[3:1], dbus_write_data_i[31:8]};

   // ---------------------------------------------------------------- buffer
   logic               w_push_req;
   logic               w_push;
   logic               w_pop;
   logic               w_drop;
   logic               w_empty;
   logic               w_full_now;
   logic [7:0]         w_head;
   logic [C_OCC_W-1:0] w_occ;
   logic [C_OCC_W-1:0] w_occ_next;

   assign w_push_req = dbus_en_i[0] && (dbus_write_addr_i == TX_ADDR);
   // A full buffer still accepts a byte when the FSM pops in the same cycle.
   assign w_push     = w_push_req && (!w_full_now || w_pop);
   assign w_drop     = w_push_req && w_full_now && !w_pop;
   assign w_occ_next = w_occ + C_OCC_W'(w_push) - C_OCC_W'(w_pop);

`ifdef UART_TX_FIFO_EN
   logic w_fifo_full;
   logic w_fifo_empty;

   uart_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .data_i  (dbus_write_data_i[7:0]),
      .data_o  (w_head),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty),
      .count_o (w_occ)
   );

   assign w_full_now = w_fifo_full;
   assign w_empty    = w_fifo_empty;
`else
   logic       r_hold_valid;
   logic [7:0] r_hold_data;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
      end else if (w_push) begin
         r_hold_valid <= 1'b1;
         r_hold_data  <= dbus_write_data_i[7:0];
      end else if (w_pop) begin
         r_hold_valid <= 1'b0;
      end
   end

   assign w_head     = r_hold_data;
   assign w_occ      = r_hold_valid;
   assign w_full_now = r_hold_valid;
   assign w_empty    = !r_hold_valid;
`endif

   // ---------------------------------------------------------------- FSM
   uart_tx_state_e     r_state;
   uart_tx_state_e     w_state_next;
   logic [C_CNT_W-1:0] r_baud;
   logic [C_CNT_W-1:0] w_baud_next;
   logic [2:0]         r_bit;
   logic [2:0]         w_bit_next;
   logic [7:0]         r_shift;
   logic [7:0]         w_shift_next;
   logic               w_tx_next;
   logic               w_bit_end;
   logic               r_tx;
   logic               r_busy;
   logic               r_full;
   logic               r_ovf;

   assign w_bit_end = (r_baud == C_CNT_LAST);

   always_comb begin
      w_state_next = r_state;
      w_baud_next  = r_baud + C_CNT_W'(1);
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_pop        = 1'b0;
      w_tx_next    = 1'b1;
      case (r_state)
         IDLE: begin
            w_baud_next = '0;
            if (!w_empty) begin
               w_state_next = START;
               w_pop        = 1'b1;
               w_shift_next = w_head;
            end
         end
         START: begin
            w_tx_next = 1'b0;
            if (w_bit_end) begin
               w_state_next = DATA;
               w_baud_next  = '0;
               w_bit_next   = '0;
            end
         end
         DATA: begin
            w_tx_next = r_shift[r_bit];
            if (w_bit_end) begin
               w_baud_next = '0;
               w_bit_next  = r_bit + 3'd1;
               if (r_bit == 3'd7) w_state_next = STOP;
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_baud_next = '0;
               // Chain straight into the next start bit when data is waiting.
               if (!w_empty) begin
                  w_state_next = START;
                  w_pop        = 1'b1;
                  w_shift_next = w_head;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
            w_baud_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_full  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_baud  <= w_baud_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
         // Busy follows the FSM's next state plus any byte already queued,
         // so it rises one edge after the write and drops on re-entry to IDLE.
         r_busy  <= (w_state_next != IDLE) || !w_empty;
         r_full  <= (w_occ_next == C_OCC_FULL);
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   assign tx_o       = r_tx;
   assign busy_o     = r_busy;
   assign full_o     = r_full;
   assign overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_mmio                                               |
// | Purpose  : Self-checking bench for uart_tx_mmio: directed scenarios plus |
// |            randomized bus traffic against a frame-position model, and a |
// |            line receiver that decodes tx_o back into bytes.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_tx_mmio;

   localparam int          CLK_FREQ = 100_000_000;
   localparam int          BAUD     = 10_000_000;
   localparam int          DIV      = CLK_FREQ / BAUD;
   localparam int          FRAME    = 10 * DIV;
   localparam logic [31:0] TX_ADDR  = 32'h4000_0000;
`ifdef UART_TX_FIFO_EN
   localparam int          DEPTH    = 4;
`else
   localparam int          DEPTH    = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        tx;
   logic        busy;
   logic        full;
   logic        ovf;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   uart_tx_mmio #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (4),
      .TX_ADDR    (TX_ADDR)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .dbus_en_i         (en),
      .dbus_write_addr_i (addr),
      .dbus_write_data_i (wdata),
      .tx_o              (tx),
      .busy_o            (busy),
      .full_o            (full),
      .overflow_o        (ovf)
   );

   // Reference model: queue of pending bytes, and the position inside the
   // current frame (0..FRAME-1) when a frame is on the line.
   logic [7:0] m_q[$];
   logic [7:0] m_done[$];
   bit         m_active = 1'b0;
   int         m_pos    = 0;
   logic [7:0] m_cur    = '0;
   logic       m_tx, m_busy, m_full, m_ovf;

   // Line receiver state.
   bit         rx_busy = 1'b0;
   int         rx_pos  = 0;
   logic [7:0] rx_byte = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic frame_level(input logic [7:0] b, input int pos);
      int slot;
      slot = pos / DIV;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return b[slot-1];
   endfunction

   task automatic model_edge(input logic r, input logic [3:0] e, input logic [31:0] a,
                             input logic [31:0] d);
      int occ;
      bit last, pop, hit;
      if (!r) begin
         m_q.delete();
         m_active = 1'b0;
         m_pos    = 0;
         m_tx     = 1'b1;
         m_busy   = 1'b0;
         m_full   = 1'b0;
         m_ovf    = 1'b0;
         return;
      end
      hit  = e[0] && (a == TX_ADDR);
      occ  = m_q.size();
      m_tx = m_active ? frame_level(m_cur, m_pos) : 1'b1;
      last = m_active && (m_pos == FRAME - 1);
      if (last) m_done.push_back(m_cur);
      pop  = (occ > 0) && (!m_active || last);
      if (pop) begin
         m_cur    = m_q.pop_front();
         m_active = 1'b1;
         m_pos    = 0;
      end else if (last) begin
         m_active = 1'b0;
      end else if (m_active) begin
         m_pos++;
      end
      if (hit) begin
         if (occ < DEPTH || pop) m_q.push_back(d[7:0]);
         else                    m_ovf = 1'b1;
      end
      m_busy = m_active || (occ > 0);
      m_full = (m_q.size() == DEPTH);
   endtask

   task automatic receive(input logic r);
      if (!r) begin
         rx_busy = 1'b0;
      end else if (!rx_busy) begin
         if (tx === 1'b0) begin
            rx_busy = 1'b1;
            rx_pos  = 0;
         end
      end else begin
         rx_pos++;
         if ((rx_pos % DIV == DIV / 2) && (rx_pos / DIV >= 1) && (rx_pos / DIV <= 8))
            rx_byte[rx_pos / DIV - 1] = tx;
         if (rx_pos == FRAME - 1) begin
            rx_busy = 1'b0;
            check("rx_frame_expected", 32'(m_done.size() > 0), 32'd1);
            if (m_done.size() > 0) check("rx_byte", rx_byte, m_done.pop_front());
         end
      end
   endtask

   task automatic step(input logic r, input logic [3:0] e, input logic [31:0] a,
                       input logic [31:0] d);
      rst_n = r;
      en    = e;
      addr  = a;
      wdata = d;
      @(posedge clk);
      cyc++;
      model_edge(r, e, a, d);
      #1;
      check("tx", tx, m_tx);
      check("busy", busy, m_busy);
      check("full", full, m_full);
      check("overflow", ovf, m_ovf);
      receive(r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] d);
      step(1'b1, 4'h1, TX_ADDR, d);
   endtask

   initial begin
      logic [3:0]  e;
      logic [31:0] a;
      int          rate;

      // Reset state
      for (int i = 0; i < 3; i++) step(1'b0, 4'h1, TX_ADDR, 32'hA5);

      // Single byte 0x55
      wr(32'h0000_0055);
      idle(FRAME + 10);

      // Wrong byte lane, wrong address
      step(1'b1, 4'h2, TX_ADDR, 32'h0000_0077);
      step(1'b1, 4'h1, TX_ADDR + 32'h4, 32'h0000_0077);
      idle(5);

      // Back-to-back frames
      wr(32'h41);
      wr(32'h42);
      wr(32'h43);
      idle(3 * FRAME + 20);

      // Six consecutive writes: fills the buffer and overflows
      for (int i = 0; i < 6; i++) wr(32'h60 + 32'(i));
      idle(6 * FRAME + 20);

      // Reset 37 cycles into a frame with another byte queued
      wr(32'hC3);
      wr(32'h3C);
      idle(37);
      step(1'b0, 4'h1, TX_ADDR, 32'hFF);
      idle(FRAME + 50);

      // Randomized traffic: blocks alternate between sparse and dense writes
      rate = 2;
      for (int i = 0; i < 4000; i++) begin
         if (i % 400 == 0) rate = ($urandom_range(0, 1) == 0) ? 2 : 25;
         if ($urandom_range(0, 999) < 3) begin
            step(1'b0, 4'($urandom), TX_ADDR, $urandom);
         end else if ($urandom_range(0, 99) < rate) begin
            e = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h1;
            a = ($urandom_range(0, 5) == 0) ? TX_ADDR + 32'h4 : TX_ADDR;
            step(1'b1, e, a, $urandom);
         end else begin
            e = 4'($urandom) & 4'hE;
            step(1'b1, e, TX_ADDR, $urandom);
         end
      end

      idle((DEPTH + 1) * FRAME + 20);
      check("rx_pending_frames", 32'(m_done.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
